branch_predictor: RTL and testbench

- Branch direction predictor for the RISC-V core; the consumer of the execute-stage branch comparator's taken result.
- Fetch side: looks up a table of 2-bit saturating counters and drives a taken/not-taken prediction plus the table index used.
- Resolve side: receives the actual outcome from execute, trains the indexed counter, flags a mispredict and keeps statistics counters.

---
 rtl/branch_predictor.sv | 92 +++++++++
 tb/tb_branch_predictor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor: 2-bit saturating-counter direction predictor + stats.     |
// | Optional global-history (gshare) indexing via BP_GSHARE_EN. Rev 1.0         |
// +----------------------------------------------------------------------------+
module branch_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  input  logic                 res_valid,
  input  logic [IDX_BITS-1:0]  res_idx,
  input  logic                 res_taken,
  input  logic                 res_pred,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int                   ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           ctr_q [ENTRIES];
  logic [1:0]           ctr_d [ENTRIES];
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [IDX_BITS-1:0]  fetch_idx;

  // fetch_valid is trace-only; the index uses just the word-address bits
  logic unused_fetch;
  assign unused_fetch = ^{fetch_valid, fetch_pc};

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (res_valid) ghr_d = {ghr_q[IDX_BITS-2:0], res_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
`endif

  assign pred_idx    = fetch_idx;
  assign pred_taken  = ctr_q[fetch_idx][1];
  assign mispredict  = res_valid & (res_taken ^ res_pred);
  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) ctr_d[i] = ctr_q[i];
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_valid) begin
      if (res_taken && (ctr_q[res_idx] != 2'b11))
        ctr_d[res_idx] = ctr_q[res_idx] + 2'b01;
      else if (!res_taken && (ctr_q[res_idx] != 2'b00))
        ctr_d[res_idx] = ctr_q[res_idx] - 2'b01;
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_ONE;
      if (mispredict && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
    end
  end

  // Reset wins over a same-cycle resolve: the pending update is discarded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_predictor: scoreboard bench for branch_predictor (BP_GSHARE_EN    |
// | aware). Rev 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        res_valid = 1'b0;
  logic [5:0]  res_idx = '0;
  logic        res_taken = 1'b0;
  logic        res_pred = 1'b0;

  logic        pred_taken, mispredict;
  logic [5:0]  pred_idx;
  logic [31:0] br_cnt, mispred_cnt;

  logic        pred_taken2, mispredict2;
  logic [5:0]  pred_idx2;
  logic [1:0]  br_cnt2, mispred_cnt2;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .PC_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .res_valid(res_valid),
    .res_idx(res_idx), .res_taken(res_taken), .res_pred(res_pred),
    .mispredict(mispredict), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  // Narrow statistics counters make the saturation boundary reachable
  branch_predictor #(.IDX_BITS(6), .PC_WIDTH(32), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken2), .pred_idx(pred_idx2), .res_valid(res_valid),
    .res_idx(res_idx), .res_taken(res_taken), .res_pred(res_pred),
    .mispredict(mispredict2), .br_cnt(br_cnt2), .mispred_cnt(mispred_cnt2)
  );

  typedef struct packed {
    logic        pt;
    logic [5:0]  idx;
    logic        mp;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          passed = 0;
  int          total = 0;
  logic [71:0] obs;
  assign obs = {pred_taken, pred_idx, mispredict, br_cnt, mispred_cnt};

  // Reference model
  logic [1:0]  m_ctr [64];
  logic [31:0] m_br, m_mis;
  logic [1:0]  m_br2, m_mis2;
  logic [5:0]  m_ghr = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_ctr[i]) m_ctr[i] <= 2'b01;
      m_br <= '0; m_mis <= '0; m_br2 <= '0; m_mis2 <= '0; m_ghr <= '0;
    end else if (res_valid) begin
      if (res_taken) begin
        if (m_ctr[res_idx] != 2'd3) m_ctr[res_idx] <= m_ctr[res_idx] + 2'd1;
      end else begin
        if (m_ctr[res_idx] != 2'd0) m_ctr[res_idx] <= m_ctr[res_idx] - 2'd1;
      end
      if (m_br != 32'hFFFF_FFFF) m_br <= m_br + 32'd1;
      if (m_br2 != 2'd3) m_br2 <= m_br2 + 2'd1;
      if (res_taken != res_pred) begin
        if (m_mis != 32'hFFFF_FFFF) m_mis <= m_mis + 32'd1;
        if (m_mis2 != 2'd3) m_mis2 <= m_mis2 + 2'd1;
      end
      m_ghr <= {m_ghr[4:0], res_taken};
    end
  end

  function automatic logic [5:0] m_idx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return pc[7:2] ^ m_ghr;
`else
    return pc[7:2];
`endif
  endfunction

  task automatic drive(input logic [31:0] pc, input logic rv, input logic [5:0] ri,
                       input logic rt, input logic rp, input logic rn);
    exp_t x;
    @(negedge clk);
    rst_n = rn; fetch_valid = rv ^ pc[2]; fetch_pc = pc;
    res_valid = rv; res_idx = ri; res_taken = rt; res_pred = rp;
    x.idx = m_idx(pc);
    x.pt  = m_ctr[x.idx][1];
    x.mp  = rv & (rt != rp);
    x.bc  = m_br;
    x.mc  = m_mis;
    sb.push_back(x);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_valid = 1'b0;
    repeat (2) @(posedge clk);
    drive(32'h104, 0, 0, 0, 0, 1);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL reset_sb: got %h expected %h", obs, e); else passed++;
    total++;
    if ({pred_idx, pred_taken, br_cnt, mispred_cnt} !== {6'd1, 1'b0, 32'd0, 32'd0})
      $display("FAIL reset_const: got idx=%0d pt=%0b br=%0d mis=%0d expected idx=1 pt=0 br=0 mis=0",
               pred_idx, pred_taken, br_cnt, mispred_cnt);
    else passed++;
  endtask

  task automatic test_train();
    drive(32'h104, 1, 6'd1, 1, 0, 1);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL train_res_sb: got %h expected %h", obs, e); else passed++;
    total++;
    if (mispredict !== 1'b1) $display("FAIL train_mispredict: got %0b expected 1", mispredict);
    else passed++;
    drive(32'h104, 0, 0, 0, 0, 1);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL train_next_sb: got %h expected %h", obs, e); else passed++;
    total++;
    if ({pred_taken, br_cnt, mispred_cnt} !== {1'b1, 32'd1, 32'd1})
      $display("FAIL train_next_const: got pt=%0b br=%0d mis=%0d expected pt=1 br=1 mis=1",
               pred_taken, br_cnt, mispred_cnt);
    else passed++;
  endtask

  task automatic test_saturation();
    logic tk [9]     = '{1, 1, 1, 0, 0, 0, 0, 1, 0};
    logic rv [9]     = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic exp_pt [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    drive(32'h0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL sat_reset_sb: got %h expected %h", obs, e); else passed++;
    for (int i = 0; i < 9; i++) begin
      drive(32'h104, rv[i], 6'd1, tk[i], 0, 1);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL sat_sb step %0d: got %h expected %h", i, obs, e); else passed++;
      total++;
      if (pred_taken !== exp_pt[i])
        $display("FAIL sat_pt step %0d: got %0b expected %0b", i, pred_taken, exp_pt[i]);
      else passed++;
    end
  endtask

  task automatic test_alias_hazard();
    drive(32'h104, 1, 6'd1, 1, 0, 1);
    drive(32'h104, 1, 6'd1, 1, 1, 1);
    drive(32'h204, 0, 0, 0, 0, 1);
    total++;
    if ({pred_idx, pred_taken} !== {6'd1, 1'b1})
      $display("FAIL alias_const: got idx=%0d pt=%0b expected idx=1 pt=1", pred_idx, pred_taken);
    else passed++;
    drive(32'h104, 1, 6'd1, 0, 1, 1);
    drive(32'h104, 1, 6'd1, 0, 1, 1);
    total++;
    if (pred_taken !== 1'b1) $display("FAIL hazard_same_cycle: got %0b expected 1", pred_taken);
    else passed++;
    drive(32'h104, 0, 0, 0, 0, 1);
    total++;
    if (pred_taken !== 1'b0) $display("FAIL hazard_next_cycle: got %0b expected 0", pred_taken);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front(); total++;
      if (e !== e) passed--;
      total--;
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        drive(32'(i << 2), 1, 6'(i), r[0] ^ i[0], 0, 1);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL mid_train_sb %0d: got %h expected %h", i, obs, e); else passed++;
      end
    drive(32'h104, 1, 6'd1, 1, 1, 0);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL mid_reset_sb: got %h expected %h", obs, e); else passed++;
    for (int i = 0; i < 64; i++) begin
      drive(32'(i << 2), 0, 0, 0, 0, 1);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL mid_scan_sb %0d: got %h expected %h", i, obs, e); else passed++;
      total++;
      if ({pred_idx, pred_taken, br_cnt, mispred_cnt} !== {6'(i), 1'b0, 32'd0, 32'd0})
        $display("FAIL mid_scan_const %0d: got idx=%0d pt=%0b br=%0d mis=%0d expected pt=0 br=0 mis=0",
                 i, pred_idx, pred_taken, br_cnt, mispred_cnt);
      else passed++;
    end
  endtask

  task automatic test_stat_sat();
    drive(32'h0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      drive(32'h10, 1, 6'd4, 1, 0, 1);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL stat_sb %0d: got %h expected %h", i, obs, e); else passed++;
    end
    drive(32'h10, 0, 0, 0, 0, 1);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL stat_final_sb: got %h expected %h", obs, e); else passed++;
    total++;
    if ({br_cnt, mispred_cnt, br_cnt2, mispred_cnt2} !== {32'd6, 32'd6, 2'd3, 2'd3})
      $display("FAIL stat_saturate: got br=%0d mis=%0d br2=%0d mis2=%0d expected 6 6 3 3",
               br_cnt, mispred_cnt, br_cnt2, mispred_cnt2);
    else passed++;
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    drive(32'h0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    drive(32'h0, 1, 6'd5, 1, 0, 1);
    e = sb.pop_front();
    drive(32'h0, 1, 6'd9, 1, 1, 1);
    e = sb.pop_front();
    drive(32'h104, 0, 0, 0, 0, 1);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL gshare_sb: got %h expected %h", obs, e); else passed++;
    total++;
    if (pred_idx !== 6'h02) $display("FAIL gshare_idx: got %h expected 02", pred_idx);
    else passed++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] pc;
    logic [5:0]  ri;
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 3) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
      ri = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      drive(pc, 1'($urandom_range(0, 1)), ri, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 59) != 0));
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL rand_sb %0d: got %h expected %h", n, obs, e); else passed++;
      total++;
      if ({br_cnt2, mispred_cnt2} !== {m_br2, m_mis2})
        $display("FAIL rand_small_cnt %0d: got %0d/%0d expected %0d/%0d",
                 n, br_cnt2, mispred_cnt2, m_br2, m_mis2);
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_train();
    test_saturation();
    test_alias_hazard();
    test_reset_mid();
`endif
    test_stat_sat();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
